acc_trace_uart: RTL and testbench
=================================

// Module: acc_trace_uart
// PURPOSE
//  Downstream consumer of the processor core. Watches the accumulator (and carry) outputs and logs every change.
//  Each change is queued in a small FIFO and serialised as 8N1 UART frames on a single tx pin,
//  giving a cycle-independent execution trace for bring-up on the board.
// PARAMETERS
//  CLKS_PER_BIT  434  clk cycles per UART bit (50 MHz / 115200); legal >= 2
//  FIFO_DEPTH    8    trace entries buffered; power of two, >= 2
// PORTS
//  clk          in   1  main clock, all logic on posedge
//  rst_n        in   1  asynchronous, active-low reset
//  acc          in   8  processor accumulator value
//  cy           in   1  processor carry flag
//  tx           out  1  UART serial output, idle high
//  busy         out  1  high while a frame is being shifted or the FIFO is non-empty
//  overflow     out  1  sticky: a change was dropped because the FIFO was full
//  fifo_level   out  $clog2(FIFO_DEPTH)+1  entries currently queued
// BEHAVIOUR
//  Reset (async, rst_n=0): tx=1, busy=0, overflow=0, fifo_level=0; prev={cy,acc} register=9'h000; FSM=IDLE.
//  Change detect: at every edge, {cy,acc} is compared against prev and prev is loaded with {cy,acc}.
//   A mismatch at edge N pushes the new {cy,acc} into the FIFO at edge N.
//  Push and pop rules:
//   - Push when full and no pop this edge: entry dropped, overflow<=1 until reset.
//   - Push on a full FIFO with a pop at the same edge: accepted, level unchanged.
//   - Push on an empty FIFO at the same edge as an idle pop: no bypass; the pop waits one cycle.
//  TX FSM (states IDLE, START, DATA, STOP):
//   - IDLE: FIFO non-empty -> pop the head into the shift register, go to START, tx=0 from the next edge.
//     Latency: change sampled at edge N -> tx falls after edge N+1.
//   - START: hold for CLKS_PER_BIT cycles, then go to DATA.
//   - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles; bit counter 0..7.
//   - STOP: tx=1 for CLKS_PER_BIT cycles; then pop the next entry if the FIFO is non-empty (START, no idle gap),
//     else go to IDLE.
//  Baud counter: counts 0..CLKS_PER_BIT-1 and wraps; it is reset on every state entry.
//  Per event without TRACE_CY_EN: one frame carrying acc.
//  Reset mid-frame: frame aborted, tx=1 immediately, queued entries discarded.
//  acc unchanged for many cycles: no frames are sent. Identical re-writes of acc are not logged.
// CONFIGURATION
//  TRACE_CY_EN defined:
//   - The FIFO entry is 9 bits. Each event sends 2 frames: acc, then {7'b0,cy}.
//   - A cy-only change is logged.
//  TRACE_CY_EN undefined:
//   - The FIFO entry is 8 bits and change detect compares acc only.
//   - prev holds acc only; a cy-only change is ignored.
// STRUCTURE
//  Shared include UartDefs.v: FSM state encodings, UART_DATA_BITS=8, IDLE_LEVEL=1'b1, entry-width macro.
//  Sub-module sync_fifo (WIDTH, DEPTH): push/pop/full/empty/level, first-word registered output.
//  Top level: change detect, TX FSM, baud counter, bit counter.
// TESTING  (CLKS_PER_BIT=4, FIFO_DEPTH=4)
//  1. Reset, hold acc=0 for 100 cycles -> tx stays 1, busy=0, no frame.
//  2. acc 00->A5 at edge N -> tx low after N+1 for 4 clk; bits 1,0,1,0,0,1,0,1 at 4 clk each; stop 1; fifo_level back to 0.
//  3. acc 01,02,03 on consecutive edges -> three back-to-back frames 01,02,03 with no idle between stop and start.
//  4. Six distinct acc values in 6 cycles while the first frame is shifting -> the first 5 are sent
//     (1 in shifter + 4 queued), the 6th is dropped; overflow=1 and stays 1.
//  5. rst_n=0 during DATA bit 3 -> tx=1 at once, fifo_level=0, overflow=0; after release no stale frame.
//  6. TRACE_CY_EN: cy 0->1 with acc=3C held -> frames 3C then 01; without the macro -> no frame.

Source files
------------

// File: rtl/acc_trace_uart_pkg.sv
// Shared definitions for the accumulator trace UART: frame constants, FSM states, FIFO entry type.
// TRACE_CY_EN widens the entry to carry the carry flag alongside acc.
package acc_trace_uart_pkg;

    localparam int   UART_DATA_BITS = 8;
    localparam logic IDLE_LEVEL     = 1'b1;

`ifdef TRACE_CY_EN
    localparam int ENTRY_W = UART_DATA_BITS + 1;
`else
    localparam int ENTRY_W = UART_DATA_BITS;
`endif

    typedef logic [ENTRY_W-1:0] entry_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_t;

endpackage

// File: rtl/acc_trace_uart_fifo.sv
// Generic synchronous FIFO; head word is read straight from registered storage, no bypass.
// Latency: a push is visible at dout one edge later; pop and push on a full FIFO are both honoured.
// Backpressure: pushes on a full FIFO without a simultaneous pop are ignored; caller watches full.
module acc_trace_uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign full  = (level == (AW+1)'(DEPTH));
    assign empty = (level == '0);
    assign rd_en = pop && !empty;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign wr_en = push && (!full || rd_en);
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/acc_trace_uart.sv
// Logs every acc change (and carry changes when TRACE_CY_EN is defined) as 8N1 UART frames on tx.
// Latency: change sampled at edge N -> start bit driven from edge N+1; queued frames follow back to back.
// Backpressure: none upstream; FIFO_DEPTH entries buffered, further changes dropped with sticky overflow.
module acc_trace_uart
    import acc_trace_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    acc,
    input  logic                          cy,
    output logic                          tx,
    output logic                          busy,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

    entry_t          cur;
    entry_t          prev;
    entry_t          fifo_dout;
    logic            push;
    logic            pop;
    logic            fifo_full;
    logic            fifo_empty;

    tx_state_t       state;
    logic [BAUD_W-1:0] baud_cnt;
    logic [2:0]      bit_cnt;
    logic [7:0]      shreg;
    logic            baud_last;
    logic            frame2_pend;
    logic [7:0]      frame2_dat;

`ifdef TRACE_CY_EN
    assign cur = {cy, acc};
`else
    logic unused_cy;
    assign cur       = acc;
    assign unused_cy = cy;
`endif

    assign push      = (cur != prev);
    assign baud_last = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
    // Pop only from IDLE or at the end of a stop bit; the carry frame of a pending event goes first.
    assign pop       = !fifo_empty &&
                       ((state == ST_IDLE) || (state == ST_STOP && baud_last && !frame2_pend));
    assign busy      = (state != ST_IDLE) || !fifo_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev     <= '0;
            overflow <= 1'b0;
        end else begin
            prev <= cur;
            if (push && fifo_full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    acc_trace_uart_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (cur),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            baud_cnt    <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            tx          <= IDLE_LEVEL;
            frame2_pend <= 1'b0;
            frame2_dat  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    tx <= IDLE_LEVEL;
                end
                ST_START: begin
                    if (baud_last) begin
                        state    <= ST_DATA;
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        tx       <= shreg[0];
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                ST_DATA: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if (bit_cnt == 3'(UART_DATA_BITS - 1)) begin
                            state <= ST_STOP;
                            tx    <= IDLE_LEVEL;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            shreg   <= {1'b0, shreg[7:1]};
                            tx      <= shreg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                ST_STOP: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if (frame2_pend) begin
                            frame2_pend <= 1'b0;
                            shreg       <= frame2_dat;
                            state       <= ST_START;
                            tx          <= ~IDLE_LEVEL;
                        end else begin
                            state <= ST_IDLE;
                            tx    <= IDLE_LEVEL;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    tx    <= IDLE_LEVEL;
                end
            endcase

            // Loading a new entry overrides whatever the state arm chose above.
            if (pop) begin
                shreg    <= fifo_dout[7:0];
                state    <= ST_START;
                baud_cnt <= '0;
                tx       <= ~IDLE_LEVEL;
`ifdef TRACE_CY_EN
                frame2_pend <= 1'b1;
                frame2_dat  <= {7'b0, fifo_dout[8]};
`endif
            end
        end
    end

endmodule

// File: tb/tb_acc_trace_uart.sv
// Directed bench for acc_trace_uart: a UART receiver model pops expected bytes from a scoreboard queue.
// Build with TRACE_CY_EN defined to also expect the carry frame after every acc frame.
module tb_acc_trace_uart;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;
`ifdef TRACE_CY_EN
    localparam int FPE       = 2;
    localparam int CY_FRAMES = 2;
`else
    localparam int FPE       = 1;
    localparam int CY_FRAMES = 0;
`endif

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    acc   = 8'h00;
    logic          cy    = 1'b0;
    logic          tx;
    logic          busy;
    logic          overflow;
    logic [LW-1:0] fifo_level;

    int         checks    = 0;
    int         errors    = 0;
    int         cyc       = 0;
    int         frames_rx = 0;
    int         rx_n      = -1;
    int         rx_k;
    logic [7:0] rx_sh     = 8'h00;
    logic [7:0] rx_exp;
    logic [7:0] exp_q[$];
    int         rx_starts[$];

    acc_trace_uart #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .acc        (acc),
        .cy         (cy),
        .tx         (tx),
        .busy       (busy),
        .overflow   (overflow),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic push_event(input logic [7:0] a);
        exp_q.push_back(a);
`ifdef TRACE_CY_EN
        exp_q.push_back({7'b0, cy});
`endif
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || busy !== 1'b0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_drain_in_time"}, 32'(n < budget), 32'd1);
    endtask

    // UART receiver: samples mid-bit, pops the scoreboard at each stop bit.
    always @(negedge clk) begin
        if (!rst_n) begin
            rx_n = -1;
        end else if (rx_n < 0) begin
            if (tx === 1'b0) begin
                rx_n = 0;
                rx_starts.push_back(cyc);
            end
        end else begin
            rx_n++;
        end
        if (rst_n && rx_n >= 0 && (rx_n % CPB) == CPB / 2) begin
            rx_k = rx_n / CPB;
            if (rx_k == 0) begin
                check("rx_start_bit", 32'(tx), 32'd0);
            end else if (rx_k <= 8) begin
                rx_sh = {tx, rx_sh[7:1]};
            end else begin
                check("rx_stop_bit", 32'(tx), 32'd1);
                check("rx_frame_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    rx_exp = exp_q.pop_front();
                    check("rx_data", 32'(rx_sh), 32'(rx_exp));
                end
                frames_rx++;
            end
        end
        if (rx_n == 10 * CPB - 1) rx_n = -1;
    end

    initial begin
        logic [9:0] frame;
        logic       all_high;
        int         base;
        int         sidx;

        // 1: reset state, then acc held at 0
        repeat (3) @(negedge clk);
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_overflow", 32'(overflow), 32'd0);
        check("reset_level", 32'(fifo_level), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        all_high = 1'b1;
        repeat (100) begin
            @(negedge clk);
            all_high = all_high & tx;
        end
        check("idle_tx_high", 32'(all_high), 32'd1);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_frames", 32'(frames_rx), 32'd0);

        // 2: single A5 frame, bit-exact waveform
        @(posedge clk);
        #1 acc = 8'hA5;
        push_event(8'hA5);
        @(posedge clk);
        @(negedge clk);
        check("a5_tx_before_start", 32'(tx), 32'd1);
        check("a5_level_queued", 32'(fifo_level), 32'd1);
        frame = {1'b1, 8'hA5, 1'b0};
        for (int i = 0; i < 10 * CPB; i++) begin
            @(negedge clk);
            check($sformatf("a5_wave_%0d", i), 32'(tx), 32'(frame[i / CPB]));
            if (i == 0) check("a5_level_popped", 32'(fifo_level), 32'd0);
        end
        wait_drain("a5", 200);
        check("a5_level_end", 32'(fifo_level), 32'd0);
        check("a5_busy_end", 32'(busy), 32'd0);

        // 3: three consecutive changes, back-to-back frames
        sidx = rx_starts.size();
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk);
            #1 acc = 8'(i);
            push_event(8'(i));
        end
        wait_drain("b2b", 600);
        check("b2b_frames", 32'(rx_starts.size() - sidx), 32'(3 * FPE));
        for (int i = sidx + 1; i < rx_starts.size(); i++) begin
            check($sformatf("b2b_gap_%0d", i - sidx), 32'(rx_starts[i] - rx_starts[i - 1]), 32'(10 * CPB));
        end

        // 4: six changes in six cycles, the sixth overflows
        base = frames_rx;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1 acc = 8'h10 + 8'(i);
            if (i < 5) push_event(8'h10 + 8'(i));
        end
        @(posedge clk);
        @(negedge clk);
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_level_full", 32'(fifo_level), 32'(DEPTH));
        wait_drain("ovf", 1000);
        repeat (50) @(negedge clk);
        check("ovf_frames", 32'(frames_rx - base), 32'(5 * FPE));
        check("ovf_sticky", 32'(overflow), 32'd1);

        // 5: reset during data bit 3
        @(posedge clk);
        #1 acc = 8'h21;
        push_event(8'h21);
        @(posedge clk);
        #1 acc = 8'h22;
        push_event(8'h22);
        repeat (18) @(posedge clk);
        #1;
        check("rst_mid_bit3", 32'(tx), 32'd0);
        check("rst_mid_level", 32'(fifo_level), 32'd1);
        rst_n = 1'b0;
        acc   = 8'h00;
        #1;
        exp_q.delete();
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        base = frames_rx;
        repeat (100) @(negedge clk);
        check("rst_no_stale_frame", 32'(frames_rx - base), 32'd0);
        check("rst_busy_after", 32'(busy), 32'd0);

        // 6: carry-only change with acc held
        @(posedge clk);
        #1 acc = 8'h3C;
        push_event(8'h3C);
        wait_drain("cy_pre", 300);
        base = frames_rx;
        @(posedge clk);
        #1 cy = 1'b1;
`ifdef TRACE_CY_EN
        push_event(8'h3C);
`endif
        repeat (150) @(negedge clk);
        wait_drain("cy", 300);
        check("cy_frames", 32'(frames_rx - base), 32'(CY_FRAMES));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
